// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: bus widths, FSM states and
// read/write encoding.
package mem_responder_pkg;

    localparam int ADR_W  = 30;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // True when no address bits above the backed array are set.
    function automatic logic adr_in_range(input logic [ADR_W-1:0] adr, input int addr_bits);
        return (adr >> addr_bits) == '0;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-wide RAM with one synchronous read port and one synchronous
// byte-lane write port. Contents are never reset.
module mem_word_array
    import mem_responder_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_adr,
    output logic [DATA_W-1:0]    rd_data,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_adr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [BE_W-1:0]      wr_be
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_adr];
        end
        if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) begin
                    mem[wr_adr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: captures one read or byte-enabled write, waits
// LATENCY cycles, then completes it with a one-cycle done pulse.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADR_W-1:0]  adr,
    inout  wire  [DATA_W-1:0] data,
    input  logic [BE_W-1:0]   byteen,
    input  logic              rwb,
    input  logic              en,
    output logic              done,
    output logic              err
);

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t state, next_state;
    logic [3:0] cnt, next_cnt;
    logic capture, enter_resp;

    logic [ADDR_BITS-1:0] adr_q;
    logic [DATA_W-1:0]    data_q;
    logic [BE_W-1:0]      be_q;
    logic                 rwb_q;
    logic                 oor_q;

    logic                 live_oor;
    logic [ADDR_BITS-1:0] req_adr;
    logic [DATA_W-1:0]    req_data;
    logic [BE_W-1:0]      req_be;
    logic                 req_rwb;
    logic                 req_oor;

    logic                 rd_en, wr_en, data_oe;
    logic [DATA_W-1:0]    rd_data, rd_word;

    assign live_oor = ~adr_in_range(adr, ADDR_BITS);

    // With zero latency the array is accessed on the capture edge itself,
    // so the live inputs stand in for the not-yet-loaded request registers.
    assign req_adr  = (state == S_IDLE) ? adr[ADDR_BITS-1:0] : adr_q;
    assign req_data = (state == S_IDLE) ? data               : data_q;
    assign req_be   = (state == S_IDLE) ? byteen             : be_q;
    assign req_rwb  = (state == S_IDLE) ? rwb                : rwb_q;
    assign req_oor  = (state == S_IDLE) ? live_oor           : oor_q;

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        capture    = 1'b0;
        enter_resp = 1'b0;
        case (state)
            S_IDLE: begin
                if (en) begin
                    capture = 1'b1;
                    if (LAT == 4'd0) begin
                        next_state = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        next_state = S_WAIT;
                        next_cnt   = LAT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd1) begin
                    next_state = S_RESP;
                    next_cnt   = 4'd0;
                    enter_resp = 1'b1;
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            adr_q  <= '0;
            data_q <= '0;
            be_q   <= '0;
            rwb_q  <= READ;
            oor_q  <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (capture) begin
                adr_q  <= adr[ADDR_BITS-1:0];
                data_q <= data;
                be_q   <= byteen;
                rwb_q  <= rwb;
                oor_q  <= live_oor;
            end
        end
    end

    // Reset gating keeps a zero-latency capture from committing while held in reset.
    assign rd_en = enter_resp & (req_rwb == READ);
    assign wr_en = enter_resp & (req_rwb == WRITE) & ~req_oor & reset;

    mem_word_array #(.ADDR_BITS(ADDR_BITS)) u_array (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_adr  (req_adr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_adr  (req_adr),
        .wr_data (req_data),
        .wr_be   (req_be)
    );

    assign done    = (state == S_RESP);
    assign err     = done & oor_q;
    assign data_oe = done & (rwb_q == READ);
    assign rd_word = oor_q ? '0 : rd_data;
    assign data    = data_oe ? rd_word : 'z;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: LATENCY=2 instance driven through a scoreboard,
// plus a LATENCY=0 instance for the zero-wait handshake.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int ABITS = 10;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [29:0] adr;
    logic [3:0]  byteen;
    logic        rwb, en, done, err;
    logic [31:0] wdata;
    logic        wdrive;
    wire  [31:0] data;
    assign data = wdrive ? wdata : 'z;

    logic [29:0] adr0;
    logic [3:0]  byteen0;
    logic        rwb0, en0, done0, err0;
    logic [31:0] wdata0;
    logic        wdrive0;
    wire  [31:0] data0;
    assign data0 = wdrive0 ? wdata0 : 'z;

    mem_responder #(.ADDR_BITS(ABITS), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .adr(adr), .data(data), .byteen(byteen),
        .rwb(rwb), .en(en), .done(done), .err(err)
    );

    mem_responder #(.ADDR_BITS(ABITS), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .adr(adr0), .data(data0), .byteen(byteen0),
        .rwb(rwb0), .en(en0), .done(done0), .err(err0)
    );

    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q[$];          // {is_read, err, read data}
    logic [31:0] model [0:1023];

    task automatic run_req(input logic r, input logic [29:0] a, input logic [31:0] d,
                           input logic [3:0] be, input string name);
        logic [33:0] exp;
        logic oor;
        int cyc;
        logic got;
        oor = (a >> ABITS) != 0;
        if (r) begin
            exp = {1'b1, oor, (oor ? 32'h0 : model[a[9:0]])};
        end else begin
            exp = {1'b0, oor, 32'h0};
            if (!oor) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) model[a[9:0]][8*i +: 8] = d[8*i +: 8];
                end
            end
        end
        exp_q.push_back(exp);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || dut.data_oe !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: done=%b oe=%b want done=0 oe=0", name, done, dut.data_oe);
        end
        adr = a; rwb = r; byteen = be; en = 1'b1;
        if (!r) begin
            wdata = d; wdrive = 1'b1;
        end
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                checks++;
                if (dut.data_oe !== 1'b0) begin
                    errors++;
                    $display("FAIL %s data driven before done (cycle %0d)", name, cyc);
                end
            end
        end
        checks++;
        exp = exp_q.pop_front();
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
        end else begin
            checks++;
            if (cyc != LAT + 1) begin
                errors++;
                $display("FAIL %s latency: got %0d want %0d", name, cyc, LAT + 1);
            end
            checks++;
            if (err !== exp[32]) begin
                errors++;
                $display("FAIL %s err: got %b want %b", name, err, exp[32]);
            end
            checks++;
            if (dut.data_oe !== exp[33]) begin
                errors++;
                $display("FAIL %s drive enable: got %b want %b", name, dut.data_oe, exp[33]);
            end
            if (exp[33]) begin
                checks++;
                if (data !== exp[31:0]) begin
                    errors++;
                    $display("FAIL %s rdata: got %h want %h", name, data, exp[31:0]);
                end
            end
        end
        en = 1'b0;
        wdrive = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (done !== 1'b0 || err !== 1'b0 || dut.data_oe !== 1'b0 || dut.state !== S_IDLE) begin
            errors++;
            $display("FAIL reset: done=%b err=%b oe=%b state=%0d want 0/0/0/IDLE",
                     done, err, dut.data_oe, dut.state);
        end
        checks++;
        if (done0 !== 1'b0 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL reset0: done=%b err=%b want 0/0", done0, err0);
        end
    endtask

    task automatic test_write_read();
        run_req(1'b0, 30'd5, 32'hDEADBEEF, 4'hF, "wr5");
        run_req(1'b1, 30'd5, 32'h0, 4'hF, "rd5");
    endtask

    task automatic test_byteen();
        run_req(1'b0, 30'd5, 32'h000000AA, 4'b0001, "wr5_lane0");
        run_req(1'b1, 30'd5, 32'h0, 4'hF, "rd5_lane0");
        run_req(1'b0, 30'd5, 32'hFFFFFFFF, 4'b0000, "wr5_be0");
        run_req(1'b1, 30'd5, 32'h0, 4'hF, "rd5_be0");
    endtask

    task automatic test_out_of_range();
        run_req(1'b0, 30'd0, 32'hCAFEF00D, 4'hF, "wr0");
        run_req(1'b1, 30'h400, 32'h0, 4'hF, "rd_oor");
        run_req(1'b0, 30'h400, 32'h11111111, 4'hF, "wr_oor");
        run_req(1'b1, 30'd0, 32'h0, 4'hF, "rd0_noalias");
    endtask

    task automatic test_latency0();
        @(negedge clk);
        adr0 = 30'd3; rwb0 = 1'b0; byteen0 = 4'hF; wdata0 = 32'h00000055;
        wdrive0 = 1'b1; en0 = 1'b1;
        @(negedge clk);
        checks++;
        if (done0 !== 1'b1 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL lat0_wr_done: done=%b err=%b want 1/0", done0, err0);
        end
        @(negedge clk);
        checks++;
        if (done0 !== 1'b0) begin
            errors++;
            $display("FAIL lat0_single_pulse: done=%b want 0", done0);
        end
        en0 = 1'b0; wdrive0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done0 !== 1'b0) begin
                errors++;
                $display("FAIL lat0_recapture: done=%b want 0 (cycle %0d)", done0, i);
            end
        end
        adr0 = 30'd3; rwb0 = 1'b1; en0 = 1'b1;
        @(negedge clk);
        checks++;
        if (done0 !== 1'b1 || data0 !== 32'h00000055) begin
            errors++;
            $display("FAIL lat0_rd: done=%b data=%h want 1/00000055", done0, data0);
        end
        en0 = 1'b0;
        @(negedge clk);
        checks++;
        if (done0 !== 1'b0) begin
            errors++;
            $display("FAIL lat0_rd_end: done=%b want 0", done0);
        end
    endtask

    task automatic test_reset_in_wait();
        run_req(1'b0, 30'd7, 32'h11112222, 4'hF, "wr7_prior");
        @(negedge clk);
        adr = 30'd7; rwb = 1'b0; byteen = 4'hF; wdata = 32'h12345678;
        wdrive = 1'b1; en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (dut.state !== S_IDLE || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait: state=%0d done=%b want IDLE/0", dut.state, done);
        end
        @(negedge clk);
        reset = 1'b1; en = 1'b0; wdrive = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_done: done=%b want 0 (cycle %0d)", done, i);
            end
        end
        run_req(1'b1, 30'd7, 32'h0, 4'hF, "rd7_after_rst");
    endtask

    task automatic test_back_to_back();
        logic [29:0] a;
        run_req(1'b0, 30'd1, 32'hA5A55A5A, 4'hF, "b2b_wr1");
        run_req(1'b1, 30'd1, 32'h0, 4'hF, "b2b_rd1");
        for (int i = 16; i < 24; i++) begin
            run_req(1'b0, 30'(i), 32'($urandom), 4'hF, "init");
        end
        for (int i = 0; i < 16; i++) begin
            a = 30'($urandom_range(16, 23));
            run_req(1'($urandom_range(0, 1)), a, 32'($urandom),
                    4'($urandom_range(0, 15)), "rand");
        end
    endtask

    initial begin
        adr = '0; byteen = '0; rwb = 1'b1; en = 1'b0; wdata = '0; wdrive = 1'b0;
        adr0 = '0; byteen0 = '0; rwb0 = 1'b1; en0 = 1'b0; wdata0 = '0; wdrive0 = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b1;
        test_write_read();
        test_byteen();
        test_out_of_range();
        test_latency0();
        test_reset_in_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
